// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
package arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned CNT_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Next requester index; the 2-bit width gives the 3->0 wrap for free.
   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      return p + IDX_W'(1);
   endfunction

endpackage

// File: rtl/dec_2_4.sv
// 2-to-4 one-hot decoder with enable; all zeros when disabled.
module dec_2_4
   import arb_pkg::*;
(
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] y
);

   always_comb begin
      y = '0;
      if (en) y[idx] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold until release.
// Optional grant watchdog compiled in with `define ARB_TIMEOUT_EN.
module rr_arbiter_4
   import arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 15
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout
);

   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("rr_arbiter_4: HOLD_MAX out of range 1..255");
   end

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic             grant_valid_q, grant_valid_d;
   logic             timeout_q, timeout_d;

   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;
   logic             release_c;
   logic             hold_hit;

   // First requesting index at or after the rotating pointer.
   always_comb begin
      cand       = '0;
      pick_idx   = ptr_q;
      pick_found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = ptr_q + IDX_W'(k);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign release_c = done || !req[grant_idx_q];

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

   // Counts GRANT cycles; sits at zero in IDLE so every grant starts fresh.
   always_comb begin
      hold_cnt_d = '0;
      if (state_q == GRANT) hold_cnt_d = hold_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) hold_cnt_q <= '0;
      else     hold_cnt_q <= hold_cnt_d;
   end

   assign hold_hit = (hold_cnt_q + CNT_W'(1)) == CNT_W'(HOLD_MAX);
`else
   assign hold_hit = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      timeout_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_idx_d   = pick_idx;
               grant_valid_d = 1'b1;
               state_d       = GRANT;
            end
         end
         GRANT: begin
            // A normal release outranks the watchdog on the same cycle.
            if (release_c || hold_hit) begin
               grant_valid_d = 1'b0;
               ptr_d         = ptr_inc(grant_idx_q);
               state_d       = IDLE;
               timeout_d     = !release_c;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         timeout_q     <= timeout_d;
      end
   end

   dec_2_4 u_dec (
      .en  (grant_valid_q),
      .idx (grant_idx_q),
      .y   (grant)
   );

   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Randomized and directed bench for rr_arbiter_4 against a cycle-level reference model.
module tb_rr_arbiter_4;

   localparam int unsigned HOLD = 4;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int n_cmp;
   int n_err;
   int n_to;

   // Reference state: who holds the resource, where the search starts, grant age.
   bit m_busy;
   int m_idx;
   int m_ptr;
   int m_hold;
   bit m_to;

   rr_arbiter_4 #(.HOLD_MAX(HOLD)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One arbitration decision per clock, derived directly from the rules.
   task automatic model_step();
      m_to = 0;
      if (rst) begin
         m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
      end else if (!m_busy) begin
         for (int k = 0; k < 4; k++) begin
            if (!m_busy && req[(m_ptr + k) % 4]) begin
               m_busy = 1;
               m_idx  = (m_ptr + k) % 4;
               m_hold = 0;
            end
         end
      end else begin
         m_hold++;
         if (done || !req[m_idx]) begin
            m_busy = 0;
            m_ptr  = (m_idx + 1) % 4;
         end
`ifdef ARB_TIMEOUT_EN
         else if (m_hold == HOLD) begin
            m_busy = 0;
            m_ptr  = (m_idx + 1) % 4;
            m_to   = 1;
         end
`endif
      end
   endtask

   task automatic cycle(input logic [3:0] r, input logic d, input logic rs);
      logic [3:0] exp_grant;
      req  = r;
      done = d;
      rst  = rs;
      @(posedge clk);
      model_step();
      #1;
      exp_grant = m_busy ? 4'(1 << m_idx) : 4'b0000;
      check("grant",       32'(grant),       32'(exp_grant));
      check("grant_idx",   32'(grant_idx),   32'(m_idx));
      check("grant_valid", 32'(grant_valid), 32'(m_busy));
      check("timeout",     32'(timeout),     32'(m_to));
      if (timeout) n_to++;
   endtask

   initial begin
      n_cmp = 0; n_err = 0; n_to = 0;
      m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
      req = '0; done = 1'b0; rst = 1'b1;

      // Reset with all requests pending, then first grant to requester 0.
      cycle(4'b1111, 1'b0, 1'b1);
      cycle(4'b1111, 1'b0, 1'b1);
      check("reset_grant", 32'(grant), 32'h0);
      cycle(4'b1111, 1'b0, 1'b0);
      check("first_grant", 32'(grant), 32'h1);

      // Rotation 0 -> 1 -> 2 -> 3 -> 0 with one idle cycle between grants.
      for (int k = 1; k <= 4; k++) begin
         cycle(4'b1111, 1'b1, 1'b0);
         check("rot_idle", 32'(grant_valid), 32'h0);
         cycle(4'b1111, 1'b0, 1'b0);
         check("rot_idx", 32'(grant_idx), 32'(k % 4));
      end

      // Serve index 2 so the pointer sits at 3, then wrap to 0 and 1.
      cycle(4'b1111, 1'b1, 1'b0);
      cycle(4'b0100, 1'b0, 1'b0);
      check("serve2", 32'(grant), 32'h4);
      cycle(4'b0100, 1'b1, 1'b0);
      cycle(4'b0011, 1'b0, 1'b0);
      check("wrap_idx0", 32'(grant_idx), 32'h0);
      cycle(4'b0011, 1'b1, 1'b0);
      cycle(4'b0011, 1'b0, 1'b0);
      check("skip_idx1", 32'(grant_idx), 32'h1);

      // Withdrawal of 2 as 3 rises; done in IDLE is ignored.
      cycle(4'b0010, 1'b1, 1'b0);
      cycle(4'b0100, 1'b0, 1'b0);
      cycle(4'b1000, 1'b0, 1'b0);
      check("withdraw_rel", 32'(grant_valid), 32'h0);
      cycle(4'b1000, 1'b1, 1'b0);
      check("grant3", 32'(grant), 32'h8);

      // Mid-grant reset while requester 1 holds the grant.
      cycle(4'b1000, 1'b1, 1'b0);
      cycle(4'b0010, 1'b0, 1'b0);
      check("grant1", 32'(grant), 32'h2);
      cycle(4'b0010, 1'b0, 1'b1);
      check("midrst", 32'(grant), 32'h0);
      cycle(4'b0010, 1'b0, 1'b0);
      check("post_rst", 32'(grant_idx), 32'h1);
      cycle(4'b0010, 1'b1, 1'b0);

      // Continuous single requester without done: watchdog or indefinite hold.
      n_to = 0;
      for (int k = 0; k < 25; k++) cycle(4'b0001, 1'b0, 1'b0);
`ifdef ARB_TIMEOUT_EN
      check("to_count", 32'(n_to), 32'd5);
`else
      check("to_count", 32'(n_to), 32'd0);
      check("held", 32'(grant), 32'h1);
`endif

      // Random traffic.
      for (int k = 0; k < 800; k++) begin
         cycle(4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
